grf_write_arbiter: RTL and testbench

Write-side front end of the general register file. It merges two writeback sources into the single GRF write port: the in-order pipeline writeback (primary) and the late-result path for multi-cycle units and bus loads (secondary). The secondary path is buffered in a small FIFO. The arbiter registers the chosen write and drives the GRF's WE/A3/WD3/PC inputs. It sits between the W stage and the GRF, and exports pending-write flags to the hazard unit.

---
 rtl/grf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_grf_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: in-order writeback has priority over a small FIFO of late results.
// Optional committed-write trace enabled by defining GRF_TRACE_EN.
module grf_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_we,
  input  logic [4:0]    p_addr,
  input  logic [31:0]   p_data,
  input  logic [31:0]   p_pc,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_addr,
  input  logic [31:0]   s_data,
  input  logic [31:0]   s_pc,
  output logic          grf_we,
  output logic [4:0]    grf_a3,
  output logic [31:0]   grf_wd3,
  output logic [31:0]   grf_pc,
  input  logic [4:0]    q_addr1,
  input  logic [4:0]    q_addr2,
  output logic          q_pend1,
  output logic          q_pend2,
  output logic [AW:0]   level
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  wr_t              fifo_mem [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [DEPTH-1:0] fifo_kill;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic full;
  logic enq;
  logic p_acc;
  logic pop;
  wr_t  head;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    s_ready = !full;
    p_acc   = p_we && (p_addr != 5'd0);
    enq     = s_valid && !full && (s_addr != 5'd0);
    pop     = !p_acc && (count != '0);
    head    = fifo_mem[rd_ptr];
    level   = count;
  end

  // Payload storage needs no reset; validity is tracked by fifo_vld.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= '{addr: s_addr, data: s_data, pc: s_pc};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_vld  <= '0;
      fifo_kill <= '0;
      grf_we    <= 1'b0;
      grf_a3    <= 5'd0;
      grf_wd3   <= 32'd0;
      grf_pc    <= 32'd0;
    end else begin
      // An accepted primary write supersedes every older queued write to the same register.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (p_acc && fifo_vld[i] && (fifo_mem[i].addr == p_addr)) fifo_kill[i] <= 1'b1;
      end
      if (pop) begin
        fifo_vld[rd_ptr]  <= 1'b0;
        fifo_kill[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end
      if (enq) begin
        fifo_vld[wr_ptr]  <= 1'b1;
        fifo_kill[wr_ptr] <= 1'b0;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (p_acc) begin
        grf_we  <= 1'b1;
        grf_a3  <= p_addr;
        grf_wd3 <= p_data;
        grf_pc  <= p_pc;
      end else if (pop && !fifo_kill[rd_ptr]) begin
        grf_we  <= 1'b1;
        grf_a3  <= head.addr;
        grf_wd3 <= head.data;
        grf_pc  <= head.pc;
      end else begin
        grf_we  <= 1'b0;
      end
    end
  end

  // Pending-write lookup for the hazard unit.
  always_comb begin
    q_pend1 = grf_we && (grf_a3 == q_addr1);
    q_pend2 = grf_we && (grf_a3 == q_addr2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && !fifo_kill[i] && (fifo_mem[i].addr == q_addr1)) q_pend1 = 1'b1;
      if (fifo_vld[i] && !fifo_kill[i] && (fifo_mem[i].addr == q_addr2)) q_pend2 = 1'b1;
    end
    if (q_addr1 == 5'd0) q_pend1 = 1'b0;
    if (q_addr2 == 5'd0) q_pend2 = 1'b0;
  end

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we && (grf_a3 != 5'd0)) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd3);
  end
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed self-checking bench for grf_write_arbiter.
module tb_grf_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data, p_pc;
  logic        s_valid, s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data, s_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd3, grf_pc;
  logic [4:0]  q_addr1, q_addr2;
  logic        q_pend1, q_pend2;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  grf_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_pc(s_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd3(grf_wd3), .grf_pc(grf_pc),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_we = 0; p_addr = 0; p_data = 0; p_pc = 0;
    s_valid = 0; s_addr = 0; s_data = 0; s_pc = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle(); q_addr1 = 0; q_addr2 = 0;
    cyc(); cyc();
    reset = 1;
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0d exp 0", grf_we); end
    checks++; if (grf_a3 !== 5'd0) begin errors++; $display("FAIL rst_a3: got %0d exp 0", grf_a3); end
    checks++; if (grf_wd3 !== 32'd0 || grf_pc !== 32'd0) begin errors++; $display("FAIL rst_wd3_pc: got %h/%h exp 0/0", grf_wd3, grf_pc); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d exp 0", level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %0d exp 1", s_ready); end
  endtask

  task automatic test_primary();
    p_we = 1; p_addr = 5; p_data = 32'h1234; p_pc = 32'h3000;
    cyc();
    idle();
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd5) begin errors++; $display("FAIL prim_we_a3: got %0d/%0d exp 1/5", grf_we, grf_a3); end
    checks++; if (grf_wd3 !== 32'h1234 || grf_pc !== 32'h3000) begin errors++; $display("FAIL prim_data_pc: got %h/%h exp 1234/3000", grf_wd3, grf_pc); end
    cyc();
    checks++; if (grf_we !== 1'b0 || grf_a3 !== 5'd5 || grf_wd3 !== 32'h1234) begin errors++; $display("FAIL prim_hold: got %0d/%0d/%h exp 0/5/1234", grf_we, grf_a3, grf_wd3); end
  endtask

  task automatic test_fill_drain();
    q_addr1 = 16;
    for (int k = 0; k < 4; k++) begin
      p_we = 1; p_addr = 1; p_data = 32'h100 + k; p_pc = 32'h4000;
      s_valid = 1; s_addr = 5'(16 + k); s_data = 32'hA0 + k; s_pc = 32'h5000 + 4 * k;
      cyc();
    end
    idle();
    #1;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d exp 4", level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %0d exp 0", s_ready); end
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd1 || grf_wd3 !== 32'h103) begin errors++; $display("FAIL fill_prim: got %0d/%0d/%h exp 1/1/103", grf_we, grf_a3, grf_wd3); end
    checks++; if (q_pend1 !== 1'b1) begin errors++; $display("FAIL fill_qpend: got %0d exp 1", q_pend1); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (grf_we !== 1'b1 || grf_a3 !== 5'(16 + k) || grf_wd3 !== 32'hA0 + k || grf_pc !== 32'h5000 + 4 * k || level !== 3'(3 - k)) begin
        errors++;
        $display("FAIL drain_%0d: got we=%0d a3=%0d wd3=%h pc=%h lvl=%0d exp 1/%0d/%h/%h/%0d",
                 k, grf_we, grf_a3, grf_wd3, grf_pc, level, 16 + k, 32'hA0 + k, 32'h5000 + 4 * k, 3 - k);
      end
    end
    cyc();
    checks++; if (grf_we !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL drain_end: got %0d/%0d exp 0/0", grf_we, level); end
  endtask

  task automatic test_kill();
    q_addr1 = 8; q_addr2 = 9;
    s_valid = 1; s_addr = 8; s_data = 32'hAAAA; s_pc = 32'h6000;
    cyc();
    idle();
    #1;
    checks++; if (level !== 3'd1 || q_pend1 !== 1'b1) begin errors++; $display("FAIL kill_queued: got lvl=%0d pend=%0d exp 1/1", level, q_pend1); end
    checks++; if (q_pend2 !== 1'b0) begin errors++; $display("FAIL kill_qpend2: got %0d exp 0", q_pend2); end
    p_we = 1; p_addr = 8; p_data = 32'hBBBB; p_pc = 32'h6100;
    cyc();
    idle();
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd8 || grf_wd3 !== 32'hBBBB || level !== 3'd1) begin errors++; $display("FAIL kill_prim: got %0d/%0d/%h/%0d exp 1/8/bbbb/1", grf_we, grf_a3, grf_wd3, level); end
    cyc();
    checks++; if (grf_we !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL kill_drain: got we=%0d lvl=%0d exp 0/0", grf_we, level); end
    checks++; if (q_pend1 !== 1'b0) begin errors++; $display("FAIL kill_qpend: got %0d exp 0", q_pend1); end
    checks++; if (grf_wd3 !== 32'hBBBB) begin errors++; $display("FAIL kill_final: got %h exp bbbb", grf_wd3); end
    // Same-cycle enqueue is younger than the primary write and must survive.
    p_we = 1; p_addr = 9; p_data = 32'h1; p_pc = 32'h7000;
    s_valid = 1; s_addr = 9; s_data = 32'h2; s_pc = 32'h7100;
    cyc();
    idle();
    checks++; if (grf_we !== 1'b1 || grf_wd3 !== 32'h1 || level !== 3'd1 || q_pend2 !== 1'b1) begin errors++; $display("FAIL same_prim: got %0d/%h/%0d/%0d exp 1/1/1/1", grf_we, grf_wd3, level, q_pend2); end
    cyc();
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9 || grf_wd3 !== 32'h2 || grf_pc !== 32'h7100 || level !== 3'd0) begin errors++; $display("FAIL same_sec: got %0d/%0d/%h/%h/%0d exp 1/9/2/7100/0", grf_we, grf_a3, grf_wd3, grf_pc, level); end
    cyc();
  endtask

  task automatic test_addr0();
    q_addr1 = 0;
    p_we = 1; p_addr = 0; p_data = 32'hDEAD; s_valid = 1; s_addr = 0; s_data = 32'hBEEF;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL a0_ready: got %0d exp 1", s_ready); end
    cyc();
    idle();
    checks++; if (grf_we !== 1'b0 || level !== 3'd0 || q_pend1 !== 1'b0) begin errors++; $display("FAIL a0_first: got %0d/%0d/%0d exp 0/0/0", grf_we, level, q_pend1); end
    cyc();
    checks++; if (grf_we !== 1'b0 || grf_wd3 !== 32'h2) begin errors++; $display("FAIL a0_second: got %0d/%h exp 0/2", grf_we, grf_wd3); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      p_we = 1; p_addr = 1; p_data = 32'h50 + k;
      s_valid = 1; s_addr = 5'(24 + k); s_data = 32'hC0 + k; s_pc = 32'h8000;
      cyc();
    end
    idle();
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_level: got %0d exp 3", level); end
    reset = 0;
    cyc();
    reset = 1;
    checks++; if (grf_we !== 1'b0 || grf_a3 !== 5'd0 || grf_wd3 !== 32'd0 || grf_pc !== 32'd0 || level !== 3'd0) begin errors++; $display("FAIL rmid_clear: got %0d/%0d/%h/%h/%0d exp all 0", grf_we, grf_a3, grf_wd3, grf_pc, level); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (grf_we !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rmid_after_%0d: got %0d/%0d exp 0/0", k, grf_we, level); end
    end
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 4; k++) begin
      p_we = 1; p_addr = 2; p_data = 32'h60 + k;
      s_valid = 1; s_addr = 5'(20 + k); s_data = 32'hD0 + k; s_pc = 32'h9000;
      cyc();
    end
    idle();
    s_valid = 1; s_addr = 30; s_data = 32'hEEEE; s_pc = 32'h9100;
    #1;
    checks++; if (level !== 3'd4 || s_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got lvl=%0d rdy=%0d exp 4/0", level, s_ready); end
    cyc();
    s_valid = 0; s_addr = 0;
    checks++; if (level !== 3'd3 || grf_we !== 1'b1 || grf_a3 !== 5'd20) begin errors++; $display("FAIL full_pop: got lvl=%0d we=%0d a3=%0d exp 3/1/20", level, grf_we, grf_a3); end
    for (int k = 1; k < 4; k++) begin
      cyc();
      checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'(20 + k) || grf_wd3 !== 32'hD0 + k) begin errors++; $display("FAIL full_drain_%0d: got %0d/%0d/%h exp 1/%0d/%h", k, grf_we, grf_a3, grf_wd3, 20 + k, 32'hD0 + k); end
    end
    cyc();
    checks++; if (grf_we !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL full_end: got %0d/%0d exp 0/0", grf_we, level); end
  endtask

  initial begin
    test_reset();
    test_primary();
    test_fill_drain();
    test_kill();
    test_addr0();
    test_reset_mid();
    test_full_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
